// File: rtl/pc_fetch_unit.sv
// PC register and instruction fetch sequencer: IDLE -> REQ -> HOLD, with jump/branch target selection.
// Optional PC_ALIGN_CHECK_EN adds a sticky FAULT state and the misaligned output.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] branch_offset_sl2,
  input  logic        branch_taken,
  input  logic        jump,
  input  logic [25:0] jump_index,
  input  logic        stall,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic [31:0] pc,
`ifdef PC_ALIGN_CHECK_EN
  output logic        misaligned,
`endif
  output logic [31:0] pc_plus4
);

`ifdef PC_ALIGN_CHECK_EN
  typedef enum logic [1:0] {IDLE, REQ, HOLD, FAULT} state_t;
`else
  typedef enum logic [1:0] {IDLE, REQ, HOLD} state_t;
`endif

  state_t      state, state_nxt;
  logic [31:0] target, next_pc;
  logic        advance;
  logic        tgt_misal;

  assign pc_plus4 = pc + 32'd4;
  assign advance  = (state == HOLD) && !stall;

  // Jump wins over branch; targets only matter on the HOLD->REQ edge.
  always_comb begin
    target = pc_plus4;
    if (jump)              target = {pc_plus4[31:28], jump_index, 2'b00};
    else if (branch_taken) target = pc_plus4 + branch_offset_sl2;
  end

`ifdef PC_ALIGN_CHECK_EN
  assign tgt_misal = (target[1:0] != 2'b00);
  assign next_pc   = target;
`else
  assign tgt_misal = 1'b0;
  assign next_pc   = target & 32'hFFFF_FFFC;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = REQ;
      REQ:     if (imem_ready) state_nxt = HOLD;
      HOLD: begin
        if (!stall) begin
`ifdef PC_ALIGN_CHECK_EN
          state_nxt = tgt_misal ? FAULT : REQ;
`else
          state_nxt = REQ;
`endif
        end
      end
`ifdef PC_ALIGN_CHECK_EN
      FAULT:   state_nxt = FAULT;
`endif
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    imem_req  = (state == REQ);
    imem_addr = pc;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc          <= RESET_PC;
      instr       <= 32'd0;
      instr_valid <= 1'b0;
`ifdef PC_ALIGN_CHECK_EN
      misaligned  <= 1'b0;
`endif
    end else begin
      if ((state == REQ) && imem_ready) begin
        instr       <= imem_rdata;
        instr_valid <= 1'b1;
      end
      if (advance) begin
`ifdef PC_ALIGN_CHECK_EN
        if (tgt_misal) misaligned <= 1'b1;
        else begin
          pc          <= next_pc;
          instr_valid <= 1'b0;
        end
`else
        pc          <= next_pc;
        instr_valid <= 1'b0;
`endif
      end
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: directed scenarios plus randomized traffic against a fetch-level model.
module tb_pc_fetch_unit;
  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] branch_offset_sl2 = 32'd0;
  logic        branch_taken = 1'b0;
  logic        jump = 1'b0;
  logic [25:0] jump_index = 26'd0;
  logic        stall = 1'b0;
  logic        imem_ready = 1'b0;
  logic [31:0] imem_rdata = 32'd0;
  logic        imem_req;
  logic [31:0] imem_addr, instr, pc, pc_plus4;
  logic        instr_valid;
`ifdef PC_ALIGN_CHECK_EN
  logic        misaligned;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  // Fetch-level model: has the unit started, does it hold an instruction, has it faulted.
  logic [31:0] m_pc = RST_PC, m_instr = 32'd0;
  bit          m_started = 0, m_valid = 0, m_fault = 0;

  pc_fetch_unit #(.RESET_PC(RST_PC)) dut (
    .clk(clk), .rst(rst), .branch_offset_sl2(branch_offset_sl2), .branch_taken(branch_taken),
    .jump(jump), .jump_index(jump_index), .stall(stall), .imem_ready(imem_ready),
    .imem_rdata(imem_rdata), .imem_req(imem_req), .imem_addr(imem_addr), .instr(instr),
    .instr_valid(instr_valid), .pc(pc),
`ifdef PC_ALIGN_CHECK_EN
    .misaligned(misaligned),
`endif
    .pc_plus4(pc_plus4)
  );

  always #5 clk = ~clk;

  task automatic step();
    logic [31:0] tgt;
    @(posedge clk);
    if (rst) begin
      m_pc = RST_PC; m_instr = 32'd0; m_valid = 0; m_started = 0; m_fault = 0;
    end else if (!m_started) m_started = 1;
    else if (m_fault) begin end
    else if (!m_valid) begin
      if (imem_ready) begin m_instr = imem_rdata; m_valid = 1; end
    end else if (!stall) begin
      if (jump)              tgt = ((m_pc + 32'd4) & 32'hF000_0000) | ({6'd0, jump_index} << 2);
      else if (branch_taken) tgt = m_pc + 32'd4 + branch_offset_sl2;
      else                   tgt = m_pc + 32'd4;
`ifdef PC_ALIGN_CHECK_EN
      if (tgt % 4 != 0) m_fault = 1;
      else begin m_pc = tgt; m_valid = 0; end
`else
      m_pc = tgt - (tgt % 4); m_valid = 0;
`endif
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(); step();
    n_cmp++; if (pc !== RST_PC) begin n_bad++; $display("FAIL reset_pc: got %h want %h", pc, RST_PC); end
    n_cmp++; if (instr !== 32'd0) begin n_bad++; $display("FAIL reset_instr: got %h want 0", instr); end
    n_cmp++; if (instr_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", instr_valid); end
    n_cmp++; if (imem_req !== 1'b0) begin n_bad++; $display("FAIL reset_req: got %b want 0", imem_req); end
    n_cmp++; if (pc_plus4 !== RST_PC + 32'd4) begin n_bad++; $display("FAIL reset_pc4: got %h want %h", pc_plus4, RST_PC + 32'd4); end
`ifdef PC_ALIGN_CHECK_EN
    n_cmp++; if (misaligned !== 1'b0) begin n_bad++; $display("FAIL reset_misal: got %b want 0", misaligned); end
`endif
  endtask

  task automatic test_sequential();
    logic [31:0] exp_pc [6] = '{32'h0, 32'h0, 32'h4, 32'h4, 32'h8, 32'h8};
    bit          exp_v  [6] = '{0, 1, 0, 1, 0, 1};
    rst = 1'b0; imem_ready = 1'b1; stall = 1'b0;
    for (int i = 0; i < 6; i++) begin
      imem_rdata = $urandom;
      step();
      n_cmp++; if (imem_addr !== exp_pc[i]) begin n_bad++; $display("FAIL seq_addr[%0d]: got %h want %h", i, imem_addr, exp_pc[i]); end
      n_cmp++; if (instr_valid !== exp_v[i]) begin n_bad++; $display("FAIL seq_valid[%0d]: got %b want %b", i, instr_valid, exp_v[i]); end
      n_cmp++; if (imem_req !== !exp_v[i]) begin n_bad++; $display("FAIL seq_req[%0d]: got %b want %b", i, imem_req, !exp_v[i]); end
      if (exp_v[i]) begin
        n_cmp++; if (instr !== m_instr) begin n_bad++; $display("FAIL seq_instr[%0d]: got %h want %h", i, instr, m_instr); end
      end
    end
  endtask

  // Reach pc=0x100 by jump, then branch backwards by 16 bytes from pc+4.
  task automatic test_branch();
    jump = 1'b1; jump_index = 26'h40;
    step();
    jump = 1'b0;
    n_cmp++; if (imem_addr !== 32'h100) begin n_bad++; $display("FAIL jump_to_100: got %h want 00000100", imem_addr); end
    step();
    branch_taken = 1'b1; branch_offset_sl2 = 32'hFFFF_FFF0;
    step();
    branch_taken = 1'b0;
    n_cmp++; if (imem_addr !== 32'h0F4) begin n_bad++; $display("FAIL branch_back: got %h want 000000f4", imem_addr); end
    step();
  endtask

  task automatic test_jump_priority();
    branch_taken = 1'b1; branch_offset_sl2 = 32'h1000_0000 - 32'h0F8;
    step();
    branch_taken = 1'b0;
    n_cmp++; if (pc !== 32'h1000_0000) begin n_bad++; $display("FAIL branch_fwd: got %h want 10000000", pc); end
    step();
    jump = 1'b1; branch_taken = 1'b1; jump_index = 26'h40; branch_offset_sl2 = $urandom;
    step();
    jump = 1'b0; branch_taken = 1'b0;
    n_cmp++; if (imem_addr !== 32'h1000_0100) begin n_bad++; $display("FAIL jump_prio: got %h want 10000100", imem_addr); end
    step();
  endtask

  task automatic test_wrap();
    branch_taken = 1'b1; branch_offset_sl2 = 32'hFFFF_FFFC - 32'h1000_0104;
    step();
    branch_taken = 1'b0;
    n_cmp++; if (pc !== 32'hFFFF_FFFC) begin n_bad++; $display("FAIL wrap_pc: got %h want fffffffc", pc); end
    n_cmp++; if (pc_plus4 !== 32'h0) begin n_bad++; $display("FAIL wrap_pc4: got %h want 00000000", pc_plus4); end
    step(); step();
    n_cmp++; if (imem_addr !== 32'h0) begin n_bad++; $display("FAIL wrap_next: got %h want 00000000", imem_addr); end
  endtask

  task automatic test_wait_stall();
    logic [31:0] held;
    imem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      imem_rdata = $urandom;
      step();
      n_cmp++; if (pc !== 32'h0 || imem_req !== 1'b1 || instr_valid !== 1'b0) begin
        n_bad++; $display("FAIL wait[%0d]: pc=%h req=%b v=%b want pc=0 req=1 v=0", i, pc, imem_req, instr_valid); end
    end
    imem_ready = 1'b1; imem_rdata = 32'hCAFE_F00D;
    step();
    n_cmp++; if (instr !== 32'hCAFE_F00D || instr_valid !== 1'b1) begin
      n_bad++; $display("FAIL wait_done: instr=%h v=%b want cafef00d v=1", instr, instr_valid); end
    held = instr;
    stall = 1'b1; jump = 1'b1; jump_index = 26'h3FF_FFFF;
    for (int i = 0; i < 4; i++) begin
      imem_rdata = $urandom;
      step();
      n_cmp++; if (pc !== 32'h0 || instr !== held || instr_valid !== 1'b1 || imem_req !== 1'b0) begin
        n_bad++; $display("FAIL stall[%0d]: pc=%h instr=%h v=%b req=%b", i, pc, instr, instr_valid, imem_req); end
    end
    stall = 1'b0; jump = 1'b0;
    step();
    n_cmp++; if (pc !== 32'h4 || instr_valid !== 1'b0) begin
      n_bad++; $display("FAIL stall_release: pc=%h v=%b want 00000004 v=0", pc, instr_valid); end
  endtask

  task automatic test_reset_mid_fetch();
    imem_ready = 1'b0;
    rst = 1'b1;
    #1;
    n_cmp++; if (pc !== RST_PC || instr !== 32'd0 || instr_valid !== 1'b0 || imem_req !== 1'b0) begin
      n_bad++; $display("FAIL async_rst: pc=%h instr=%h v=%b req=%b", pc, instr, instr_valid, imem_req); end
    #1 rst = 1'b0;
    m_pc = RST_PC; m_instr = 32'd0; m_valid = 0; m_started = 0; m_fault = 0;
    imem_ready = 1'b1; imem_rdata = 32'h1234_5678;
    step();
    n_cmp++; if (instr !== 32'd0 || pc !== RST_PC || imem_req !== 1'b1) begin
      n_bad++; $display("FAIL rst_abandon: instr=%h pc=%h req=%b want 0 %h 1", instr, pc, imem_req, RST_PC); end
    imem_rdata = 32'h8765_4321;
    step();
    n_cmp++; if (instr !== 32'h8765_4321 || imem_addr !== RST_PC || instr_valid !== 1'b1) begin
      n_bad++; $display("FAIL rst_restart: instr=%h addr=%h v=%b", instr, imem_addr, instr_valid); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      rst          = ($urandom_range(0, 99) == 0);
      stall        = ($urandom_range(0, 2) == 0);
      imem_ready   = ($urandom_range(0, 2) != 0);
      imem_rdata   = $urandom;
      jump         = ($urandom_range(0, 4) == 0);
      branch_taken = ($urandom_range(0, 2) == 0);
      jump_index   = 26'($urandom);
      branch_offset_sl2 = $urandom;
`ifdef PC_ALIGN_CHECK_EN
      branch_offset_sl2[1:0] = 2'b00;
`endif
      step();
      n_cmp++; if (pc !== m_pc || imem_addr !== m_pc || pc_plus4 !== m_pc + 32'd4) begin
        n_bad++; $display("FAIL rnd_pc[%0d]: pc=%h addr=%h pc4=%h want %h", i, pc, imem_addr, pc_plus4, m_pc); end
      n_cmp++; if (instr_valid !== m_valid || imem_req !== (m_started && !m_valid && !m_fault)) begin
        n_bad++; $display("FAIL rnd_ctl[%0d]: v=%b req=%b want v=%b", i, instr_valid, imem_req, m_valid); end
      n_cmp++; if (instr !== m_instr) begin
        n_bad++; $display("FAIL rnd_instr[%0d]: got %h want %h", i, instr, m_instr); end
    end
    rst = 1'b0; stall = 1'b0; jump = 1'b0; branch_taken = 1'b0;
  endtask

`ifdef PC_ALIGN_CHECK_EN
  task automatic test_misaligned();
    logic [31:0] pc0;
    imem_ready = 1'b1;
    for (int i = 0; i < 10 && !m_valid; i++) step();
    n_cmp++; if (instr_valid !== 1'b1) begin n_bad++; $display("FAIL misal_setup: v=%b want 1", instr_valid); end
    pc0 = pc;
    branch_taken = 1'b1; branch_offset_sl2 = 32'h2;
    step();
    branch_taken = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (misaligned !== 1'b1 || imem_req !== 1'b0 || pc !== pc0) begin
        n_bad++; $display("FAIL misal[%0d]: mis=%b req=%b pc=%h want 1 0 %h", i, misaligned, imem_req, pc, pc0); end
      imem_rdata = $urandom;
      step();
    end
    rst = 1'b1;
    #1;
    n_cmp++; if (misaligned !== 1'b0) begin n_bad++; $display("FAIL misal_clear: got %b want 0", misaligned); end
    step();
    rst = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_sequential();
    test_branch();
    test_jump_priority();
    test_wrap();
    test_wait_stall();
    test_reset_mid_fetch();
    test_random();
`ifdef PC_ALIGN_CHECK_EN
    test_misaligned();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/pc_fetch_unit.md
PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the PC value loaded on reset.
REQ-002 The block SHALL have port clk  input  1  rising-edge clock; this is the block's only clock.
REQ-003 The block SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 The block SHALL have port branch_offset_sl2  input  32  word offset already shifted left by two, from the shift-left-two stage.
REQ-005 The block SHALL have port branch_taken  input  1  selects the branch target.
REQ-006 The block SHALL have port jump  input  1  selects the jump target.
REQ-007 The block SHALL have port jump_index  input  26  J-type instruction index.
REQ-008 The block SHALL have port stall  input  1  holds the current instruction.
REQ-009 The block SHALL have port imem_ready  input  1  instruction memory data valid.
REQ-010 The block SHALL have port imem_rdata  input  32  instruction memory read data.
REQ-011 The block SHALL have port imem_req  output  1  fetch request.
REQ-012 The block SHALL have port imem_addr  output  32  fetch address, always equal to pc.
REQ-013 The block SHALL have port instr  output  32  fetched instruction.
REQ-014 The block SHALL have port instr_valid  output  1  instr holds a fetched instruction.
REQ-015 The block SHALL have port pc  output  32  current PC.
REQ-016 The block SHALL have port pc_plus4  output  32  pc + 4, mod 2^32, combinational.

Function
REQ-017 The FSM SHALL have states IDLE, REQ and HOLD, plus FAULT when PC_ALIGN_CHECK_EN is defined.
REQ-018 IDLE SHALL move to REQ unconditionally on the next clk edge.
REQ-019 In REQ, imem_req SHALL be 1 (combinational from state); in every other state it SHALL be 0.
REQ-020 In REQ with imem_ready=1, the block SHALL register imem_rdata into instr, set instr_valid=1 and enter HOLD on the same edge; with imem_ready=0 it SHALL stay in REQ with pc unchanged.
REQ-021 imem_ready in IDLE, HOLD or FAULT SHALL be ignored.
REQ-022 In HOLD with stall=1, the state, pc, instr and instr_valid SHALL all hold.
REQ-023 In HOLD with stall=0, the block SHALL load pc with next_pc, clear instr_valid and enter REQ.
REQ-024 next_pc SHALL be {pc_plus4[31:28], jump_index, 2'b00} if jump=1, else pc_plus4 + branch_offset_sl2 (32-bit, wrap, no overflow flag) if branch_taken=1, else pc_plus4; jump SHALL take priority when jump=1 and branch_taken=1.
REQ-025 jump, branch_taken and branch_offset_sl2 SHALL be sampled only in HOLD with stall=0.
REQ-026 pc=32'hFFFF_FFFC SHALL yield pc_plus4=32'h0000_0000.
REQ-027 Minimum fetch-to-fetch period SHALL be 2 cycles (REQ, then HOLD) with zero-wait memory.

Reset
REQ-028 While rst=1, the block SHALL hold state=IDLE, pc=RESET_PC, instr=0, instr_valid=0, imem_req=0 and misaligned=0, all asynchronously.
REQ-029 rst asserted during REQ SHALL abandon the pending fetch; a later imem_ready SHALL NOT update instr.

Configuration
REQ-030 Macro PC_ALIGN_CHECK_EN defined: the block SHALL add port misaligned  output  1; when next_pc[1:0]!=0 in HOLD with stall=0, pc SHALL NOT update, the block SHALL enter FAULT, and misaligned SHALL be 1 from that edge until rst.
REQ-031 FAULT SHALL be exited only by rst.
REQ-032 Macro PC_ALIGN_CHECK_EN undefined: the misaligned port and FAULT state SHALL be absent, and next_pc[1:0] SHALL be forced to 2'b00.

Verification
REQ-033 Sequential fetch: release rst, imem_ready=1 held -> imem_addr 0x0, 0x4, 0x8 on every second cycle, with instr_valid pulsing 1 cycle in every 2.
REQ-034 Branch: pc=0x100, branch_taken=1, offset_sl2=0xFFFF_FFF0 -> next imem_addr=0x0F4.
REQ-035 Jump priority: pc=0x1000_0000, jump=1, branch_taken=1, jump_index=0x000_0040 -> next imem_addr=0x1000_0100.
REQ-036 Wait/stall: imem_ready=0 for 3 cycles, then stall=1 for 4 cycles -> pc stable throughout, instr_valid=1 only during HOLD, and a single address advance after stall drops.
REQ-037 Reset mid-fetch: rst pulse in REQ, imem_ready=1 one cycle later -> instr=0, pc=RESET_PC, and fetch restarts at RESET_PC.
REQ-038 With PC_ALIGN_CHECK_EN: branch_taken=1, offset_sl2=0x2 -> misaligned=1, imem_req=0, pc unchanged until rst.
